bf_data_tape: RTL

Parametrised data tape for the BF core, replacing the single-port, always-writing data memory. It honours the write enable, performs single-cycle increment/decrement read-modify-write with wrap or saturate arithmetic, and implements tape clearing as a sequential sweep. The sweep is full-depth after reset; on a CLEAR command it covers only the touched region. It sits between the BF core (cursor/op/write_val) and simulation top, exporting `busy` so the core stalls during sweeps.

---
 rtl/bf_data_tape.sv | 71 +++++++
 1 files changed

// File: rtl/bf_data_tape.sv
// bf_data_tape: BF data tape with gated writes, INC/DEC read-modify-write and sequential clear sweeps
module bf_data_tape #(
  parameter int DATA_ADDR_SIZE = 8,
  parameter int CELL_WIDTH = 8,
  parameter bit WRAP_MODE = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [DATA_ADDR_SIZE-1:0] cursor,
  input  logic [2:0]                op,
  input  logic [CELL_WIDTH-1:0]     write_val,
  output logic [CELL_WIDTH-1:0]     read_val,
  output logic                      busy,
  output logic                      touched,
  output logic [DATA_ADDR_SIZE-1:0] high_water,
  output logic                      overflow
);
  localparam int DEPTH = 1 << DATA_ADDR_SIZE;
  localparam logic [2:0] OP_WRITE = 3'd1, OP_INC = 3'd2, OP_DEC = 3'd3, OP_CLEAR = 3'd4;
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state;
  logic [DATA_ADDR_SIZE-1:0] ptr, lim;
  logic [CELL_WIDTH-1:0] mem [DEPTH];
  logic [CELL_WIDTH-1:0] cur, nxt;
  logic is_max, is_zero, modify, at_limit;
  always_comb begin
    cur = mem[cursor];
    is_max = &cur;
    is_zero = ~|cur;
    modify = (state == IDLE) && (op == OP_WRITE || op == OP_INC || op == OP_DEC);
    at_limit = (op == OP_INC && is_max) || (op == OP_DEC && is_zero);
    nxt = op == OP_WRITE ? write_val :
          op == OP_INC ? ((is_max && !WRAP_MODE) ? cur : cur + CELL_WIDTH'(1)) :
                         ((is_zero && !WRAP_MODE) ? cur : cur - CELL_WIDTH'(1));
    read_val = busy ? '0 : cur;
  end
  assign busy = (state == SWEEP);
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= SWEEP;
      ptr <= '0;
      lim <= '1;
      touched <= 1'b0;
      high_water <= '0;
      overflow <= 1'b0;
    end else if (state == SWEEP) begin
      overflow <= 1'b0;
      if (ptr == lim) state <= IDLE;
      else ptr <= ptr + DATA_ADDR_SIZE'(1);
    end else begin
      overflow <= modify && at_limit;
      if (modify) begin
        touched <= 1'b1;
        if (!touched || cursor > high_water) high_water <= cursor;
      end else if (op == OP_CLEAR && touched) begin
        state <= SWEEP;
        ptr <= '0;
        lim <= high_water;
        touched <= 1'b0;
        high_water <= '0;
      end
    end
  end
  // reset cycles leave the array alone; the sweep that follows zeroes it
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == SWEEP) mem[ptr] <= '0;
      else if (modify) mem[cursor] <= nxt;
    end
  end
endmodule
